// File: rtl/vga_timing_ctrl.sv
// VGA/HDMI raster timing generator.
// Produces x/y counters with sync, display-enable and line/frame pulses.
// Every output is registered, and each cycle's outputs describe the same pixel.
// When en is dropped, the current frame still completes before the generator stops.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FRONT  = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BACK   = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FRONT  = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BACK   = 20,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        running,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_end,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_totals
        $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 4095");
    end

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_FP   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SP   = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_BP   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_FP   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SP   = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_BP   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    state_t      state, state_n;
    phase_t      hph, hph_n, vph, vph_n;
    logic [11:0] nx, ny;
    logic        last_x, last_frame;

    // Next state, next position and next phase for the pixel presented after this edge.
    always_comb begin
        last_x     = (x == H_LAST);
        last_frame = last_x && (y == V_LAST);

        state_n = state;
        unique case (state)
            IDLE:      if (en) state_n = RUN;
            // At the last clock of a frame, en alone decides whether another frame follows.
            RUN, DRAIN: begin
                if (last_frame) state_n = en ? RUN : IDLE;
                else            state_n = en ? RUN : DRAIN;
            end
            default:   state_n = IDLE;
        endcase

        nx    = last_x ? '0 : x + 12'd1;
        ny    = last_x ? ((y == V_LAST) ? '0 : y + 12'd1) : y;
        hph_n = hph;
        vph_n = vph;

        if (state == IDLE) begin
            nx    = '0;
            ny    = '0;
            hph_n = PH_ACT;
            vph_n = PH_ACT;
        end else begin
            if      (nx == H_BP) hph_n = PH_BACK;
            else if (nx == H_SP) hph_n = PH_SYNC;
            else if (nx == H_FP) hph_n = PH_FRONT;
            else if (nx == '0)   hph_n = PH_ACT;
            if (last_x) begin
                if      (ny == V_BP) vph_n = PH_BACK;
                else if (ny == V_SP) vph_n = PH_SYNC;
                else if (ny == V_FP) vph_n = PH_FRONT;
                else if (ny == '0)   vph_n = PH_ACT;
            end
        end
    end

    // Register the state, counters, phases and all outputs together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst || state_n == IDLE) begin
            state       <= IDLE;
            hph         <= PH_ACT;
            vph         <= PH_ACT;
            x           <= '0;
            y           <= '0;
            running     <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            hph         <= hph_n;
            vph         <= vph_n;
            x           <= nx;
            y           <= ny;
            running     <= 1'b1;
            hsync       <= (hph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (vph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            de          <= (hph_n == PH_ACT) && (vph_n == PH_ACT);
            line_end    <= (nx == H_LAST);
            frame_start <= (nx == '0) && (ny == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl.
// It instantiates a default 1650x750 generator (A) and a tiny 7x5 active-low generator (B).
// The reference model tracks running plus a linear pixel index within the frame.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, rst_b, en_b;
    logic        a_running, a_hsync, a_vsync, a_de, a_line_end, a_frame_start;
    logic [11:0] a_x, a_y;
    logic        b_running, b_hsync, b_vsync, b_de, b_line_end, b_frame_start;
    logic [11:0] b_x, b_y;

    vga_timing_ctrl dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .running(a_running), .hsync(a_hsync),
        .vsync(a_vsync), .de(a_de), .x(a_x), .y(a_y), .line_end(a_line_end),
        .frame_start(a_frame_start)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .running(b_running), .hsync(b_hsync),
        .vsync(b_vsync), .de(b_de), .x(b_x), .y(b_y), .line_end(b_line_end),
        .frame_start(b_frame_start)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk      = 1'b0;

    // Reference model state: whether the generator is running, and the pixel index within the frame.
    bit a_run = 1'b0, b_run = 1'b0;
    int a_p = 0, b_p = 0;
    localparam int A_FRAME = 1650 * 750;
    localparam int B_FRAME = 7 * 5;

    function automatic logic [29:0] expect_out(input bit run, input int p,
                                               input int ha, input int hf, input int hs, input int hb,
                                               input int va, input int vf, input int vs, input int vb,
                                               input bit pol);
        int ht, ex, ey;
        bit h_on, v_on;
        ht = ha + hf + hs + hb;
        if (!run) return {1'b0, ~pol, ~pol, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        ex   = p % ht;
        ey   = p / ht;
        h_on = (ex >= ha + hf) && (ex < ha + hf + hs);
        v_on = (ey >= va + vf) && (ey < va + vf + vs);
        return {1'b1, h_on ? pol : ~pol, v_on ? pol : ~pol, (ex < ha) && (ey < va),
                ex == ht - 1, p == 0, 12'(ex), 12'(ey)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the reference model on each rising edge from the sampled rst/en.
    always @(posedge clk) begin
        if (rst_a)                begin a_run <= 1'b0; a_p <= 0; end
        else if (!a_run)          begin if (en_a) begin a_run <= 1'b1; a_p <= 0; end end
        else if (a_p == A_FRAME-1) begin a_run <= en_a; a_p <= 0; end
        else                      a_p <= a_p + 1;

        if (rst_b)                begin b_run <= 1'b0; b_p <= 0; end
        else if (!b_run)          begin if (en_b) begin b_run <= 1'b1; b_p <= 0; end end
        else if (b_p == B_FRAME-1) begin b_run <= en_b; b_p <= 0; end
        else                      b_p <= b_p + 1;
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        logic [29:0] act, exp;
        if (chk) begin
            act = {a_running, a_hsync, a_vsync, a_de, a_line_end, a_frame_start, a_x, a_y};
            exp = expect_out(a_run, a_p, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1);
            n_assert++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_a t=%0t actual=%h expected=%h", $time, act, exp);
            end
            act = {b_running, b_hsync, b_vsync, b_de, b_line_end, b_frame_start, b_x, b_y};
            exp = expect_out(b_run, b_p, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0);
            n_assert++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_b t=%0t actual=%h expected=%h", $time, act, exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        int de_cnt, fs_cnt, le_cnt, hs_low, vs_low, cnt;
        rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
        step(3);
        chk = 1'b1;
        check("a_reset_running", a_running, 0);
        check("a_reset_x", a_x, 0);
        check("a_reset_hsync", a_hsync, 0);
        check("b_reset_hsync", b_hsync, 1);
        check("b_reset_vsync", b_vsync, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        step(1);
        check("a_idle_running", a_running, 0);

        // Default timing: first line, hsync window and line_end spacing.
        en_a = 1'b1;
        step(1);
        check("a_first_frame_start", a_frame_start, 1);
        check("a_first_x", a_x, 0);
        check("a_first_de", a_de, 1);
        step(1390);
        check("a_hsync_on_x", a_x, 1390);
        check("a_hsync_on", a_hsync, 1);
        check("a_de_off", a_de, 0);
        step(39);
        check("a_hsync_last", a_hsync, 1);
        step(1);
        check("a_hsync_off", a_hsync, 0);
        step(219);
        check("a_line_end_x", a_x, 1649);
        check("a_line_end", a_line_end, 1);
        step(1);
        check("a_wrap_x", a_x, 0);
        check("a_wrap_y", a_y, 1);
        check("a_wrap_fs", a_frame_start, 0);
        step(1649);
        check("a_line_end2", a_line_end, 1);

        // Reset mid-frame wins over en, then restart one clock after release.
        rst_a = 1'b1;
        step(1);
        check("a_rst_running", a_running, 0);
        check("a_rst_y", a_y, 0);
        check("a_rst_hsync", a_hsync, 0);
        rst_a = 1'b0;
        step(1);
        check("a_restart_fs", a_frame_start, 1);
        rst_a = 1'b1; en_a = 1'b0;

        // Small active-low configuration: per-frame tallies.
        en_b = 1'b1;
        step(1);
        check("b_first_fs", b_frame_start, 1);
        de_cnt = 0; fs_cnt = 0; le_cnt = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < B_FRAME; i++) begin
            de_cnt += int'(b_de);
            fs_cnt += int'(b_frame_start);
            le_cnt += int'(b_line_end);
            hs_low += int'(!b_hsync);
            vs_low += int'(!b_vsync);
            step(1);
        end
        check("b_de_count", de_cnt, 8);
        check("b_fs_count", fs_cnt, 1);
        check("b_le_count", le_cnt, 5);
        check("b_hsync_low_count", hs_low, 5);
        check("b_vsync_low_count", vs_low, 7);
        check("b_next_fs_no_gap", b_frame_start, 1);

        // Drop en mid-frame: the frame completes, then the generator goes idle.
        step(10);
        en_b = 1'b0;
        step(24);
        check("b_drain_running", b_running, 1);
        check("b_drain_x", b_x, 6);
        check("b_drain_y", b_y, 4);
        step(1);
        check("b_drain_idle", b_running, 0);

        // Re-raise en during the drain: the next frame follows with no gap.
        en_b = 1'b1;
        step(1);
        check("b_run_fs", b_frame_start, 1);
        step(5);
        en_b = 1'b0;
        step(15);
        en_b = 1'b1;
        step(14);
        check("b_rearm_last_x", b_x, 6);
        step(1);
        check("b_rearm_fs", b_frame_start, 1);
        check("b_rearm_running", b_running, 1);

        // Toggle en every clock: the frame length is unchanged.
        cnt = 0;
        while (cnt < 100) begin
            step(1);
            cnt++;
            if (b_frame_start) break;
            en_b = (cnt < 30) ? cnt[0] : 1'b1;
        end
        check("b_toggle_frame_len", cnt, B_FRAME);

        // Reset mid-frame on B.
        step(17);
        rst_b = 1'b1;
        step(1);
        check("b_rst_running", b_running, 0);
        check("b_rst_hsync", b_hsync, 1);
        check("b_rst_x", b_x, 0);
        rst_b = 1'b0;
        step(1);
        check("b_rst_restart_fs", b_frame_start, 1);

        rst_b = 1'b1; en_b = 1'b0;
        step(3);
        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
